// File: rtl/sort_share_ctrl.sv
// -----------------------------------------------------------------------------
// sort_share_ctrl
//   Time-shares a single 16-lane bitonic sorter between NREQ requesters.
//   Each transaction takes one 16-bit raw vector and follows a three-phase
//   cycle: IDLE (round-robin grant, capture input), SORT (capture the sorted
//   result and its ones-count), and HOLD (present the response until it is
//   accepted).
//
//   Ports
//     clk         : clock, rising edge
//     rst         : synchronous active-high reset
//     req_valid   : [NREQ-1:0]    per-requester valid
//     req_data    : [16*NREQ-1:0] requester i on bits [16*i+15:16*i]
//     req_ready   : [NREQ-1:0]    one-hot grant; the transfer completes this cycle
//     resp_valid  : response available (HOLD state)
//     resp_ready  : consumer accepts the response
//     resp_data   : [15:0] sorted vector, ascending (bit 0 = minimum)
//     resp_id     : [TAGW-1:0] requester that owns resp_data
//     resp_count  : [4:0] number of ones, 0..16
//     busy        : state is not IDLE
//     sort_err    : sticky; the sorter produced a non-thermometer result
// -----------------------------------------------------------------------------

// Combinational 16-lane bitonic sorter for 1-bit keys.
// For single bits, min is AND and max is OR.
//   i_data : [15:0] unsorted vector
//   o_data : [15:0] ascending result (ones collect in the top bits)
module bitonic_sort_16 (
   input  logic [15:0] i_data,
   output logic [15:0] o_data
);

   function automatic logic [15:0] sort16(input logic [15:0] d);
      logic [15:0] v;
      logic        a;
      logic        b;
      int          l;
      v = d;
      for (int k = 2; k <= 16; k = k * 2) begin
         for (int j = k / 2; j > 0; j = j / 2) begin
            for (int i = 0; i < 16; i++) begin
               l = i ^ j;
               if (l > i) begin
                  a = v[i];
                  b = v[l];
                  // Sub-sequences with (i & k) == 0 sort ascending, the others descending.
                  if ((i & k) == 0) begin
                     v[i] = a & b;
                     v[l] = a | b;
                  end else begin
                     v[i] = a | b;
                     v[l] = a & b;
                  end
               end
            end
         end
      end
      return v;
   endfunction

   always_comb begin
      o_data = sort16(i_data);
   end

endmodule

module sort_share_ctrl #(
   parameter int NREQ = 4,
   parameter int TAGW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [15:0]          resp_data,
   output logic [TAGW-1:0]      resp_id,
   output logic [4:0]           resp_count,
   output logic                 busy,
   output logic                 sort_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SORT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_in;
   logic [15:0]     r_out;
   logic [4:0]      r_cnt;
   logic [TAGW-1:0] r_id;
   logic [TAGW-1:0] r_last_g;
   logic            r_err;

   logic [TAGW-1:0] w_gnt;
   logic            w_found;
   logic [TAGW:0]   w_sum;
   logic [15:0]     w_sorted;
   logic [4:0]      w_pop;
   logic [15:0]     w_therm;

   function automatic logic [4:0] popcount16(input logic [15:0] d);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + 5'(d[i]);
      end
      return c;
   endfunction

   bitonic_sort_16 u_sort (
      .i_data (r_in),
      .o_data (w_sorted)
   );

   assign w_pop   = popcount16(r_in);
   // A correct sort of w_pop ones leaves exactly the top w_pop bits set.
   assign w_therm = ~(16'hFFFF >> w_pop);

   // Round-robin search starting one past the last winner, with wrap.
   // The pointer only advances on a grant, so idle requesters keep their turn.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_sum   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_sum = {1'b0, r_last_g} + (TAGW+1)'(k);
         if (w_sum >= (TAGW+1)'(NREQ)) begin
            w_sum = w_sum - (TAGW+1)'(NREQ);
         end
         if (!w_found && req_valid[w_sum[TAGW-1:0]]) begin
            w_found = 1'b1;
            w_gnt   = w_sum[TAGW-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               req_ready   = NREQ'(1) << w_gnt;
               w_state_nxt = ST_SORT;
            end
         end
         ST_SORT: begin
            w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (resp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // No transfer may complete while reset is asserted.
      if (rst) begin
         req_ready = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_last_g <= TAGW'(NREQ - 1);
         r_in     <= '0;
         r_out    <= '0;
         r_cnt    <= '0;
         r_id     <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_in     <= req_data[{w_gnt, 4'b0000} +: 16];
                  r_id     <= w_gnt;
                  r_last_g <= w_gnt;
               end
            end
            ST_SORT: begin
               r_out <= w_sorted;
               r_cnt <= w_pop;
               if (w_sorted != w_therm) begin
                  r_err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign resp_valid = (r_state == ST_HOLD);
   assign resp_data  = r_out;
   assign resp_id    = r_id;
   assign resp_count = r_cnt;
   assign busy       = (r_state != ST_IDLE);
   assign sort_err   = r_err;

endmodule

// File: tb/tb_sort_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sort_share_ctrl
//   Directed bench for sort_share_ctrl (NREQ=4). Inputs change just after the
//   falling edge, and outputs are sampled 1 time unit later, well away from
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_sort_share_ctrl;

   localparam int NREQ = 4;
   localparam int TAGW = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [16*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [15:0]          resp_data;
   logic [TAGW-1:0]      resp_id;
   logic [4:0]           resp_count;
   logic                 busy;
   logic                 sort_err;

   int n_cmp  = 0;
   int n_fail = 0;

   sort_share_ctrl #(.NREQ(NREQ), .TAGW(TAGW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_count (resp_count),
      .busy       (busy),
      .sort_err   (sort_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // One full transaction from a single requester with resp_ready high.
   task automatic txn(input int r, input logic [15:0] d,
                      input logic [15:0] exp_d, input logic [4:0] exp_c);
      step();
      req_valid = 4'(1 << r);
      req_data[16*r +: 16] = d;
      #1;
      chk("txn_grant", 32'(req_ready), 32'(1 << r));
      step();
      req_valid = '0;
      #1;
      chk("txn_sort_busy", 32'(busy), 32'd1);
      chk("txn_sort_valid", 32'(resp_valid), 32'd0);
      chk("txn_sort_ready", 32'(req_ready), 32'd0);
      step();
      #1;
      chk("txn_hold_valid", 32'(resp_valid), 32'd1);
      chk("txn_hold_data", 32'(resp_data), 32'(exp_d));
      chk("txn_hold_count", 32'(resp_count), 32'(exp_c));
      chk("txn_hold_id", 32'(resp_id), 32'(r));
      chk("txn_hold_err", 32'(sort_err), 32'd0);
      step();
      #1;
      chk("txn_idle_valid", 32'(resp_valid), 32'd0);
      chk("txn_idle_busy", 32'(busy), 32'd0);
   endtask

   logic [15:0] rr_in  [4];
   logic [15:0] rr_out [4];
   logic [4:0]  rr_cnt [4];

   initial begin
      rr_in[0]  = 16'h0001; rr_out[0] = 16'h8000; rr_cnt[0] = 5'd1;
      rr_in[1]  = 16'h0003; rr_out[1] = 16'hC000; rr_cnt[1] = 5'd2;
      rr_in[2]  = 16'h0007; rr_out[2] = 16'hE000; rr_cnt[2] = 5'd3;
      rr_in[3]  = 16'h000F; rr_out[3] = 16'hF000; rr_cnt[3] = 5'd4;

      // Reset held two cycles with every requester valid.
      rst        = 1'b1;
      req_valid  = 4'hF;
      req_data   = 64'h1111_2222_3333_4444;
      resp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         #1;
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_resp_valid", 32'(resp_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      rst       = 1'b0;
      req_valid = '0;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd0);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_resp_data", 32'(resp_data), 32'd0);
      chk("post_rst_resp_id", 32'(resp_id), 32'd0);
      chk("post_rst_resp_count", 32'(resp_count), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_sort_err", 32'(sort_err), 32'd0);

      // First transaction: all valid, requester 0 wins, data 00F0.
      step();
      req_valid = 4'hF;
      req_data[15:0] = 16'h00F0;
      #1;
      chk("first_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      #1;
      chk("single_sort_valid", 32'(resp_valid), 32'd0);
      chk("single_sort_busy", 32'(busy), 32'd1);
      step();
      #1;
      chk("single_valid", 32'(resp_valid), 32'd1);
      chk("single_data", 32'(resp_data), 32'hF000);
      chk("single_count", 32'(resp_count), 32'd4);
      chk("single_id", 32'(resp_id), 32'd0);
      chk("single_err", 32'(sort_err), 32'd0);
      step();
      #1;
      chk("single_done", 32'(resp_valid), 32'd0);

      // Edge values (last winner 0 -> requester 1, then 3, then 0).
      txn(1, 16'h0000, 16'h0000, 5'd0);
      txn(3, 16'hFFFF, 16'hFFFF, 5'd16);
      txn(0, 16'h8001, 16'hC000, 5'd2);

      // Backpressure: requester 1 in HOLD for 6 stalled cycles while requester 2 waits.
      step();
      resp_ready = 1'b0;
      req_valid  = 4'b0010;
      req_data[31:16] = 16'h0F00;
      #1;
      chk("bp_grant1", 32'(req_ready), 32'b0010);
      step();
      req_valid = 4'b0100;
      req_data[47:32] = 16'h0007;
      #1;
      chk("bp_sort_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         #1;
         chk("bp_hold_valid", 32'(resp_valid), 32'd1);
         chk("bp_hold_data", 32'(resp_data), 32'hF000);
         chk("bp_hold_id", 32'(resp_id), 32'd1);
         chk("bp_hold_count", 32'(resp_count), 32'd4);
         chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
      end
      step();
      resp_ready = 1'b1;
      #1;
      chk("bp_accept_valid", 32'(resp_valid), 32'd1);
      chk("bp_accept_req_ready", 32'(req_ready), 32'd0);
      step();
      #1;
      chk("bp_grant2", 32'(req_ready), 32'b0100);
      chk("bp_idle_valid", 32'(resp_valid), 32'd0);
      step();
      req_valid = '0;
      step();
      #1;
      chk("bp_r2_data", 32'(resp_data), 32'hE000);
      chk("bp_r2_id", 32'(resp_id), 32'd2);
      chk("bp_r2_count", 32'(resp_count), 32'd3);
      step();

      // Reset while requester 3's response is held.
      resp_ready = 1'b0;
      req_valid  = 4'b1000;
      req_data[63:48] = 16'h1234;
      #1;
      chk("rh_grant", 32'(req_ready), 32'b1000);
      step();
      req_valid = '0;
      step();
      #1;
      chk("rh_hold_valid", 32'(resp_valid), 32'd1);
      chk("rh_hold_id", 32'(resp_id), 32'd3);
      chk("rh_hold_count", 32'(resp_count), 32'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      resp_ready = 1'b1;
      #1;
      chk("rh_valid", 32'(resp_valid), 32'd0);
      chk("rh_busy", 32'(busy), 32'd0);
      chk("rh_data", 32'(resp_data), 32'd0);
      chk("rh_id", 32'(resp_id), 32'd0);
      chk("rh_count", 32'(resp_count), 32'd0);
      chk("rh_err", 32'(sort_err), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk("rh_no_resp", 32'(resp_valid), 32'd0);
      end

      // Round-robin with all four valid: grant order 0,1,2,3,0,1 every 3 cycles.
      step();
      req_valid = 4'hF;
      for (int r = 0; r < NREQ; r++) begin
         req_data[16*r +: 16] = rr_in[r];
      end
      for (int n = 0; n < 6; n++) begin
         #1;
         chk("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
         step();
         #1;
         chk("rr_sort_ready", 32'(req_ready), 32'd0);
         step();
         #1;
         chk("rr_valid", 32'(resp_valid), 32'd1);
         chk("rr_id", 32'(resp_id), 32'(n % 4));
         chk("rr_data", 32'(resp_data), 32'(rr_out[n % 4]));
         chk("rr_count", 32'(resp_count), 32'(rr_cnt[n % 4]));
         step();
      end
      req_valid = '0;
      #1;
      chk("final_sort_err", 32'(sort_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
